button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end stage for the up/down counter display path.
- Takes two raw, bouncy board push-buttons (direction and pause) and produces clean, debounced, glitch-free level controls `up_down` and `pause`. These feed the counter stage directly.
- Also emits single-cycle press pulses for any other consumer.
- Each button channel is independent: 2-FF synchroniser, then counter-based debouncer, then press-edge detector, then toggle register.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button level (20 ms at 50 MHz); must be >= 1.
- BTN_ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (board keys); 0 = reads 1 when pressed.
- Internal counter width is derived as clog2(DEBOUNCE_CYCLES)+1; it is not a parameter.

Ports:
- clk  input  1  system clock (50 MHz board clock)
- reset  input  1  synchronous, active-high reset
- btn_dir_raw  input  1  raw direction button, asynchronous to clk
- btn_pause_raw  input  1  raw pause button, asynchronous to clk
- up_down  output  1  direction level: 1 = count up, 0 = count down; toggles on each accepted direction press
- pause  output  1  pause level: 1 = hold count; toggles on each accepted pause press
- dir_press  output  1  one-cycle pulse on each accepted direction press
- pause_press  output  1  one-cycle pulse on each accepted pause press

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-high, sampled on posedge clk, and has priority over all other logic.
- Reset values:
  - up_down=1, pause=0, dir_press=0, pause_press=0.
  - Sync flops and debounced state are set to the "released" level (1 if BTN_ACTIVE_LOW, else 0).
  - Debounce counters are set to 0.
- Polarity: internally, pressed is normalised to 1. All following rules use the normalised value.
- Synchroniser: two flops per channel. The raw value is visible at sync2 after 2 edges.
- Debouncer, per channel, with registers db and cnt:
  - If sync2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any sample matching db restarts the count. A glitch shorter than DEBOUNCE_CYCLES consecutive cycles never changes db.
- Press detection: a press is accepted on the edge where db goes 0->1.
  - On that same edge, the press pulse register is set to 1 and the toggle output inverts.
  - The pulse is 1 for exactly one cycle, then returns to 0.
  - A release (db 1->0) produces no pulse and no toggle.
- Latency: a raw level change first captured at edge 1 gives db, pulse and toggle updates at edge 2+DEBOUNCE_CYCLES, provided the level stays stable throughout.
- Held button: exactly one pulse per press, regardless of hold length.
- Simultaneous presses: the channels are fully independent. Both pulses and both toggles may occur on the same edge.
- Reset mid-operation:
  - The debounce state is discarded and outputs return to reset values.
  - A button still held when reset deasserts is treated as a new press: pulse and toggle occur at edge 2+DEBOUNCE_CYCLES after the first non-reset edge.
- Outputs are all registered. No combinational path exists from the raw inputs to the outputs.

Test Plan (DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1, both buttons idle at 1 unless stated):
- Reset: assert reset for 2 edges with buttons idle -> up_down=1, pause=0, dir_press=0, pause_press=0; outputs hold these values for 20 idle cycles after release.
- Clean press: btn_dir_raw=0 from before edge 1, held for 20 cycles, then released for 20 cycles -> dir_press=1 only in the cycle after edge 6; up_down 1->0 at edge 6; on release, no pulse and up_down stays 0.
- Bounce rejection: btn_pause_raw pattern 0,0,0,1,0,0,0,1, then held 1 -> pause_press never asserts, pause stays 0. Then hold 0 for 10 cycles -> one pause_press pulse and pause=1, 6 edges after the hold starts.
- Simultaneous: both raw inputs go to 0 before the same edge -> dir_press and pause_press pulse in the same cycle; up_down=0 and pause=1 on the same edge.
- Held button and second press: hold btn_dir_raw=0 for 100 cycles -> exactly one dir_press. Release for 10 cycles, then press again -> second pulse, and up_down returns to 1.
- Reset mid-debounce: press btn_dir_raw at edge 1 and pulse reset at edge 4 while the button stays held -> no pulse before reset, outputs return to reset values. dir_press then pulses at the 6th edge after reset deasserts, and up_down=0.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions two raw push-buttons into debounced toggle levels and one-cycle press pulses.
// Each channel: 2-FF synchroniser -> counter debouncer -> press-edge detect -> toggle register.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_dir_raw,
  input  logic btn_pause_raw,
  output logic up_down,
  output logic pause,
  output logic dir_press,
  output logic pause_press
);

  localparam int unsigned     CntW     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned     NumCh    = 2;
  localparam logic            Released = BTN_ACTIVE_LOW;
  localparam logic [CntW-1:0] CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  // Channel 0 is direction (resets to count up), channel 1 is pause (resets to running).
  localparam logic [NumCh-1:0] TogRst  = 2'b01;

  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] sync1_q, sync1_d;
  logic [NumCh-1:0] sync2_q, sync2_d;
  logic [NumCh-1:0] db_q, db_d;
  logic [NumCh-1:0] press_q, press_d;
  logic [NumCh-1:0] tog_q, tog_d;
  logic [CntW-1:0]  cnt_q [NumCh];
  logic [CntW-1:0]  cnt_d [NumCh];

  assign raw = {btn_pause_raw, btn_dir_raw};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    tog_d   = tog_q;
    press_d = '0;
    for (int ch = 0; ch < NumCh; ch++) begin
      cnt_d[ch] = '0;
      if (sync2_q[ch] != db_q[ch]) begin
        if (cnt_q[ch] == CntMax) begin
          db_d[ch] = sync2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
      // db and sync are kept in raw polarity; a change to the non-released level is a press.
      if ((db_d[ch] != db_q[ch]) && (db_d[ch] != Released)) begin
        press_d[ch] = 1'b1;
        tog_d[ch]   = ~tog_q[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {NumCh{Released}};
      sync2_q <= {NumCh{Released}};
      db_q    <= {NumCh{Released}};
      press_q <= '0;
      tog_q   <= TogRst;
      for (int ch = 0; ch < NumCh; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      press_q <= press_d;
      tog_q   <= tog_d;
      for (int ch = 0; ch < NumCh; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign up_down     = tog_q[0];
  assign pause       = tog_q[1];
  assign dir_press   = press_q[0];
  assign pause_press = press_q[1];

endmodule
